// File: rtl/mod_counter.sv
// mod_counter -- parametrised modulo-N event counter for the RTC chains.
//
// Synchronises the asynchronous trig input and counts its rising edges
// modulo MODULUS. Counting can run up or down, can be gated by en, and can
// be overridden by a synchronous load. A one-cycle carry pulse marks every
// wrap, so stages cascade by wiring carry of one stage to trig of the next.
//
// Parameters:
//   WIDTH       width of count and load_val
//   MODULUS     number of count states (0 .. MODULUS-1), 2 <= MODULUS <= 2**WIDTH
//   SYNC_STAGES flops in the trig synchroniser, >= 1
//
// Ports:
//   clk       in   clock; all state changes on its rising edge
//   rst       in   synchronous active-high reset
//   trig      in   asynchronous event input; each rising edge is one event
//   en        in   count enable; edges seen while low are discarded
//   up        in   direction, 1 = increment, 0 = decrement
//   load      in   synchronous load strobe (wins over a coincident event)
//   load_val  in   value to load, clamped to MODULUS-1
//   count     out  registered count
//   carry     out  one-cycle pulse on wrap in either direction
//   at_max    out  registered flag, high while count = MODULUS-1
module mod_counter #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam int unsigned      NSYNC   = SYNC_STAGES;

    logic [NSYNC-1:0] sync;
    logic             prev;
    logic             ev;
    logic [WIDTH-1:0] count_nxt;
    logic             carry_nxt;

    // Synchroniser and edge-detect history shift on every non-reset cycle,
    // independent of en and load, so a level that rises while disabled or
    // during a load is consumed rather than counted later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync[0] <= trig;
            for (int unsigned i = 1; i < NSYNC; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync[NSYNC-1];
        end
    end

    assign ev = sync[NSYNC-1] & ~prev;

    always_comb begin
        count_nxt = count;
        carry_nxt = 1'b0;
        if (load) begin
            // Out-of-range load values clamp so count never leaves 0..MODULUS-1.
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (ev && en) begin
            if (up) begin
                if (count == MAX_VAL) begin
                    count_nxt = '0;
                    carry_nxt = 1'b1;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    count_nxt = MAX_VAL;
                    carry_nxt = 1'b1;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    // at_max is derived from the next count so it lines up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            carry  <= 1'b0;
            at_max <= 1'b0;
        end else begin
            count  <= count_nxt;
            carry  <= carry_nxt;
            at_max <= (count_nxt == MAX_VAL);
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic       trig4 = 1'b0;
    logic       ctrig = 1'b0;
    logic       en = 1'b1;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] count0, count4, count_lo;
    logic [2:0] count_hi;
    logic       carry0, carry4, carry_lo, carry_hi;
    logic       at_max0, at_max4, at_max_lo, at_max_hi;

    int vectors = 0;
    int miscompares = 0;
    int carry_cnt0 = 0;
    int carry_cnt_lo = 0;
    int carry_cnt_hi = 0;

    typedef struct {
        string tag;
        int    cnt;
        int    at_max;
        int    carries;
    } exp_t;

    exp_t sb[$];
    int   model_cnt = 0;
    int   model_carries = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(10), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .trig(trig), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count0), .carry(carry0), .at_max(at_max0)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .SYNC_STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .trig(trig4), .en(1'b1), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .count(count4), .carry(carry4), .at_max(at_max4)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .SYNC_STAGES(2)) lo (
        .clk(clk), .rst(rst), .trig(ctrig), .en(1'b1), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .count(count_lo), .carry(carry_lo), .at_max(at_max_lo)
    );

    mod_counter #(.WIDTH(3), .MODULUS(6), .SYNC_STAGES(2)) hi (
        .clk(clk), .rst(rst), .trig(carry_lo), .en(1'b1), .up(1'b1), .load(1'b0),
        .load_val(3'd0), .count(count_hi), .carry(carry_hi), .at_max(at_max_hi)
    );

    always @(negedge clk) begin
        if (carry0 === 1'b1) carry_cnt0++;
        if (carry_lo === 1'b1) carry_cnt_lo++;
        if (carry_hi === 1'b1) carry_cnt_hi++;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag     = tag;
        e.cnt     = model_cnt;
        e.at_max  = (model_cnt == 9) ? 1 : 0;
        e.carries = model_carries;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".count"}, 32'(count0), 32'(e.cnt));
            chk({e.tag, ".at_max"}, 32'(at_max0), 32'(e.at_max));
            chk({e.tag, ".carries"}, 32'(carry_cnt0), 32'(e.carries));
        end
    endtask

    // One trig pulse into the main DUT; the reference model predicts the
    // outcome when the pulse is driven and the result is checked afterwards.
    task automatic pulse(input string tag, input int h, input int l);
        if (en) begin
            if (up) begin
                if (model_cnt == 9) begin
                    model_cnt = 0;
                    model_carries++;
                end else begin
                    model_cnt++;
                end
            end else begin
                if (model_cnt == 0) begin
                    model_cnt = 9;
                    model_carries++;
                end else begin
                    model_cnt--;
                end
            end
        end
        push_exp(tag);
        trig = 1'b1;
        wait_neg(h);
        trig = 1'b0;
        wait_neg(l);
        pop_check();
    endtask

    task automatic do_load(input string tag, input logic [3:0] v);
        load     = 1'b1;
        load_val = v;
        model_cnt = (v > 4'd9) ? 9 : int'(v);
        push_exp(tag);
        wait_neg(1);
        load = 1'b0;
        pop_check();
    endtask

    initial begin
        int base_lo;
        int base_hi;
        wait_neg(1);

        // Reset state.
        rst = 1'b1;
        wait_neg(2);
        chk("rst.count", 32'(count0), 32'd0);
        chk("rst.carry", 32'(carry0), 32'd0);
        chk("rst.at_max", 32'(at_max0), 32'd0);
        chk("rst.count4", 32'(count4), 32'd0);
        rst = 1'b0;
        wait_neg(1);

        // Latency: 3rd sampling edge for 2 stages, 5th for 4 stages.
        trig  = 1'b1;
        trig4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_neg(1);
            chk($sformatf("lat2.edge%0d", k), 32'(count0), (k >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("lat4.edge%0d", k), 32'(count4), (k >= 5) ? 32'd1 : 32'd0);
        end
        trig  = 1'b0;
        trig4 = 1'b0;
        wait_neg(3);
        model_cnt = 1;

        // Count up: 11 more pulses -> 2..9,0,1,2 with one carry at 9->0.
        for (int i = 0; i < 11; i++) begin
            pulse($sformatf("up%0d", i), 3, 3);
        end

        // Down and load.
        do_load("load0", 4'd0);
        up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse($sformatf("down%0d", i), 3, 3);
        end
        do_load("load15", 4'd15);

        // Enable low: edges are consumed, no late count after re-enable.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse($sformatf("dis%0d", i), 3, 3);
        end
        en = 1'b1;
        push_exp("reenable");
        wait_neg(10);
        pop_check();

        // Load coincident with an event: load wins, event is dropped.
        up = 1'b1;
        trig = 1'b1;
        wait_neg(2);
        load     = 1'b1;
        load_val = 4'd5;
        model_cnt = 5;
        push_exp("load_vs_ev");
        wait_neg(1);
        load = 1'b0;
        wait_neg(1);
        trig = 1'b0;
        wait_neg(4);
        pop_check();
        pulse("after_load", 3, 3);

        // trig held high through reset release: exactly one increment.
        rst  = 1'b1;
        trig = 1'b1;
        wait_neg(2);
        rst = 1'b0;
        model_cnt = 1;
        push_exp("rst_trig_high");
        wait_neg(6);
        pop_check();
        trig = 1'b0;
        push_exp("rst_trig_high_hold");
        wait_neg(4);
        pop_check();

        // Reset one cycle after a trig rise: the in-flight edge is lost.
        trig = 1'b1;
        wait_neg(1);
        trig = 1'b0;
        rst  = 1'b1;
        wait_neg(1);
        rst = 1'b0;
        model_cnt = 0;
        push_exp("rst_inflight");
        wait_neg(8);
        pop_check();

        // Cascade: 60 random-width pulses through mod-10 then mod-6.
        base_lo = carry_cnt_lo;
        base_hi = carry_cnt_hi;
        for (int i = 0; i < 60; i++) begin
            ctrig = 1'b1;
            wait_neg(int'($urandom_range(11, 2)));
            ctrig = 1'b0;
            wait_neg(int'($urandom_range(11, 2)));
        end
        wait_neg(20);
        chk("casc.lo_count", 32'(count_lo), 32'd0);
        chk("casc.hi_count", 32'(count_hi), 32'd0);
        chk("casc.lo_carries", 32'(carry_cnt_lo - base_lo), 32'd6);
        chk("casc.hi_carries", 32'(carry_cnt_hi - base_hi), 32'd1);
        chk("casc.hi_at_max", 32'(at_max_hi), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N event counter for the RTC datapath, replacing the plain free-running `counter` as the building block for the seconds, minutes, hours and day chains. It synchronises an asynchronous `trig` input, counts its rising edges, and supports up/down direction, enable, and synchronous load. It wraps at a programmable modulus and emits a one-cycle carry/borrow pulse, so instances cascade by wiring `carry` of one stage to `trig` of the next.

## Interface
- `WIDTH`, 4, width of `count` and `load_val`
- `MODULUS`, 10, number of count states (0 .. MODULUS-1); legal range 2 ≤ MODULUS ≤ 2**WIDTH
- `SYNC_STAGES`, 2, flops in the `trig` synchroniser; legal range ≥ 1

- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `trig`  in  1  event input, asynchronous to `clk`; each rising edge is one count event
- `en`  in  1  count enable; when low, edges are detected and discarded
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `load`  in  1  synchronous load strobe
- `load_val`  in  WIDTH  value loaded when `load` = 1
- `count`  out  WIDTH  current count, registered
- `carry`  out  1  one-cycle pulse on wrap (up: MODULUS-1 → 0; down: 0 → MODULUS-1)
- `at_max`  out  1  registered flag; high while `count` = MODULUS-1

## Operation
- Synchroniser: `trig` → `sync[0]` … `sync[SYNC_STAGES-1]`, shifted every clock. `prev` holds the previous value of `sync[SYNC_STAGES-1]`.
- Edge event: `ev = sync[SYNC_STAGES-1] & ~prev`. This is combinational and internal.
- Per rising edge of `clk`, in priority order:
  1. `rst`: `count` = 0, `carry` = 0, `at_max` = 0 (unless MODULUS-1 = 0, which is illegal), all `sync` = 0, `prev` = 0.
  2. `load`: `count` = min(`load_val`, MODULUS-1), `carry` = 0. Any coincident `ev` is discarded.
  3. `ev & en & up`: `count` = (`count` = MODULUS-1) ? 0 : `count` + 1. `carry` = 1 iff wrapped.
  4. `ev & en & ~up`: `count` = (`count` = 0) ? MODULUS-1 : `count` - 1. `carry` = 1 iff wrapped.
  5. Otherwise: `count` holds, `carry` = 0.
- `at_max` is registered from the next-state value of `count`, so it always matches `count` in the same cycle.
- The synchroniser and `prev` shift on every non-reset cycle, including during `load` and with `en` = 0. A level that rises while disabled is consumed and does not count later.
- `trig` held high through reset release is seen as a rising edge and produces exactly one count event. This is intentional: a cascaded upper stage whose lower stage's carry is high is not lost.
- Arithmetic: compare against MODULUS-1 at WIDTH bits. `count` never leaves 0 .. MODULUS-1, including after a load with an out-of-range value.

## Timing
- Event latency: `count` updates on the (SYNC_STAGES+1)-th rising `clk` edge that samples `trig` = 1. With the default, that is the 3rd edge.
- Minimum `trig` high time and low time: 1 clk period each, plus setup and hold. Narrower pulses may be missed. At most one event per 2 clk cycles.
- `carry` is high for exactly 1 cycle, in the same cycle that `count` shows the wrapped value.
- Cascade latency: each downstream stage adds SYNC_STAGES+1 cycles.
- `load` latency: 1 edge, independent of the synchroniser.
- `rst` mid-operation: it takes effect on the next edge regardless of any in-flight `trig` edge in the synchroniser. That edge is lost unless `trig` is still high after reset.

## Test plan
- Reset and count up with defaults: `rst` for 2 cycles, then 12 `trig` pulses (each 3 high, 3 low). Required: `count` goes 0,1,…,9,0,1,2; `carry` pulses once, in the cycle `count` goes 9→0; `at_max` is high only while `count` = 9.
- Latency: one `trig` rise. Required: `count` changes on exactly the 3rd sampling edge. Repeat with SYNC_STAGES=4 and require the 5th edge.
- Down and load: load 0, set `up` = 0, give 3 pulses. Required: `count` goes 9,8,7; `carry` pulses on the 0→9 step. Load 15 with MODULUS=10. Required: `count` = 9.
- Enable and priority: `en` = 0 during 4 pulses. Required: `count` unchanged and no late count after `en` = 1. Assert `load` (`load_val` = 5) on the same edge as an event. Required: `count` = 5.
- Cascade: two instances, MODULUS 10 then 6, lower `carry` → upper `trig`, 60 pulses into the lower stage. Required: final state is lower = 0, upper = 0, with exactly one upper `carry` pulse; use random pulse widths of 2–11 cycles.
- Reset corner: hold `trig` high across reset release. Required: exactly one increment, to 1. Assert `rst` one cycle after a `trig` rise. Required: `count` = 0 and no increment while `trig` stays low.
